// File: rtl/paddle_line_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// paddle_line_sequencer
//
// Initiator side of the vertical-line-drawer start/done handshake in the pong
// video path. On every frame tick it latches the paddle buttons, then for the
// left paddle and then the right paddle it asks the line drawer for an erase
// at the old position followed by a draw at the new position. It owns the
// committed paddle positions and reports them to game logic.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   frame_tick                 one-cycle pulse per frame
//   l_up, l_down, r_up, r_down paddle buttons, synchronous to clk
//   ln_start                   start request to the line drawer (level)
//   ln_done                    one-cycle completion pulse from the drawer
//   ln_x, ln_y, ln_height      line origin column, top row and length
//   color                      1 = paint paddle, 0 = erase to background
//   busy                       high whenever a frame update is in progress
//   frame_done                 one-cycle pulse once both paddles are redrawn
//   l_y, r_y                   committed paddle tops
// ---------------------------------------------------------------------------
module paddle_line_sequencer #(
    parameter int PADDLE_H = 32,
    parameter int LEFT_X   = 10,
    parameter int RIGHT_X  = 309,
    parameter int Y_MAX    = 240,
    parameter int STEP     = 2,
    parameter int Y_INIT   = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       l_up,
    input  logic       l_down,
    input  logic       r_up,
    input  logic       r_down,
    output logic       ln_start,
    input  logic       ln_done,
    output logic [8:0] ln_x,
    output logic [7:0] ln_y,
    output logic [7:0] ln_height,
    output logic       color,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] l_y,
    output logic [7:0] r_y
);

    localparam logic [8:0] STEP9  = 9'(STEP);
    localparam logic [8:0] LIMIT9 = 9'(Y_MAX - PADDLE_H);

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        ERASE_REL,
        DRAW,
        DRAW_REL
    } state_t;

    state_t state;
    state_t state_next;

    logic sel_right;
    logic lat_l_up;
    logic lat_l_down;
    logic lat_r_up;
    logic lat_r_down;

    logic [8:0] cur_y9;
    logic       mv_up;
    logic       mv_down;
    logic [7:0] new_y;

    // Candidate new position for whichever paddle is selected, worked out
    // from the buttons captured at the frame tick. The arithmetic is done in
    // 9 bits so that neither the subtraction near the top nor the addition
    // near the bottom can wrap before the clamp is applied.
    always_comb begin
        cur_y9  = {1'b0, (sel_right ? r_y : l_y)};
        mv_up   = sel_right ? lat_r_up   : lat_l_up;
        mv_down = sel_right ? lat_r_down : lat_l_down;
        new_y   = cur_y9[7:0];
        if (mv_up && !mv_down) begin
            new_y = (cur_y9 >= STEP9) ? 8'(cur_y9 - STEP9) : 8'd0;
        end else if (mv_down && !mv_up) begin
            new_y = ((cur_y9 + STEP9) <= LIMIT9) ? 8'(cur_y9 + STEP9) : 8'(LIMIT9);
        end
    end

    // State register. The async reset drops ln_start immediately because
    // ln_start is decoded straight from this register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The two REL states hold ln_start low for exactly one
    // cycle so the drawer sees a fresh rising edge for every command; ln_done
    // is only honoured in the states where a request is outstanding.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (frame_tick) state_next = ERASE;
            ERASE:     if (ln_done)    state_next = ERASE_REL;
            ERASE_REL:                 state_next = DRAW;
            DRAW:      if (ln_done)    state_next = DRAW_REL;
            DRAW_REL:  state_next = sel_right ? IDLE : ERASE;
            default:                   state_next = IDLE;
        endcase
    end

    // Moore outputs. The line y is always the selected paddle's register:
    // during ERASE it still holds the old top, and by DRAW it has been
    // overwritten with the new one, so no separate copy is needed.
    always_comb begin
        ln_start   = (state == ERASE) || (state == DRAW);
        color      = (state == DRAW);
        busy       = (state != IDLE);
        frame_done = (state == DRAW_REL) && sel_right;
        ln_x       = sel_right ? 9'(RIGHT_X) : 9'(LEFT_X);
        ln_y       = sel_right ? r_y : l_y;
        ln_height  = 8'(PADDLE_H);
    end

    // Datapath registers: buttons are captured only on an accepted frame
    // tick, a paddle's new top is committed when its erase completes, and
    // the paddle select flips to the right paddle after the left draw.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_right  <= 1'b0;
            lat_l_up   <= 1'b0;
            lat_l_down <= 1'b0;
            lat_r_up   <= 1'b0;
            lat_r_down <= 1'b0;
            l_y        <= 8'(Y_INIT);
            r_y        <= 8'(Y_INIT);
        end else begin
            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        sel_right  <= 1'b0;
                        lat_l_up   <= l_up;
                        lat_l_down <= l_down;
                        lat_r_up   <= r_up;
                        lat_r_down <= r_down;
                    end
                end
                ERASE: begin
                    if (ln_done) begin
                        if (sel_right) begin
                            r_y <= new_y;
                        end else begin
                            l_y <= new_y;
                        end
                    end
                end
                DRAW_REL: begin
                    if (!sel_right) begin
                        sel_right <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/paddle_line_sequencer.md
Name: paddle_line_sequencer

Overview:
- Initiator side of the vertical-line-drawer start/done handshake in the pong video path.
- On each frame tick it moves both paddles from button inputs. For each paddle it commands the line drawer twice: first an erase at the old position, then a draw at the new position.
- It owns the paddle position registers and reports them to game logic.

Parameters:
- PADDLE_H, 32, paddle height in pixels; drives ln_height; range 1..Y_MAX.
- LEFT_X, 10, x column of left paddle (9-bit).
- RIGHT_X, 309, x column of right paddle (9-bit).
- Y_MAX, 240, screen height in lines.
- STEP, 2, pixels moved per frame tick.
- Y_INIT, 104, reset y of both paddles.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame.
- l_up, l_down, r_up, r_down  in  1 each  paddle buttons, synchronous to clk.
- ln_start  out  1  start request to line drawer.
- ln_done  in  1  one-cycle completion pulse from line drawer.
- ln_x  out  9  line x origin.
- ln_y  out  8  line y origin (top).
- ln_height  out  8  line length, constant PADDLE_H.
- color  out  1  1 = paint paddle, 0 = erase to background; valid whenever ln_start=1.
- busy  out  1  high when not IDLE.
- frame_done  out  1  one-cycle pulse when both paddles are finished.
- l_y, r_y  out  8 each  current committed paddle tops.

Behaviour:
- Reset (async) values:
  - State IDLE; l_y = r_y = Y_INIT.
  - ln_start, color, busy, frame_done = 0.
  - Button latches = 0; paddle select = left.
- States: IDLE, ERASE, ERASE_REL, DRAW, DRAW_REL.
  - ln_start = 1 in ERASE and DRAW only (Moore, decoded from the state register).
- Transitions:
  - IDLE: frame_tick -> ERASE, paddle select = left, latch all four buttons. Otherwise stay.
  - ERASE: ln_y = old y, color = 0. Hold until ln_done; on ln_done -> ERASE_REL and commit the new y for the selected paddle.
  - ERASE_REL: ln_start = 0 for exactly one cycle, so the drawer returns to its idle state -> DRAW.
  - DRAW: ln_y = committed new y, color = 1. Hold until ln_done -> DRAW_REL.
  - DRAW_REL: ln_start = 0 for one cycle.
    - If the selected paddle is left: select right -> ERASE.
    - If right: pulse frame_done -> IDLE.
- ln_x = LEFT_X or RIGHT_X per selected paddle. ln_height = PADDLE_H at all times.
- Wait for ln_done is unbounded; no timeout.
- Movement arithmetic, computed from the latched buttons:
  - up & ~down: new = (y >= STEP) ? y - STEP : 0.
  - down & ~up: new = (y + STEP <= Y_MAX - PADDLE_H) ? y + STEP : Y_MAX - PADDLE_H.
  - Both or neither pressed: new = y.
  - Compare with 9-bit intermediates so no 8-bit wrap occurs.
- An erase/draw pair is issued even when a paddle does not move.
- Boundary and simultaneous cases:
  - frame_tick while busy: ignored, not queued.
  - Button changes after the latch point: ignored until the next frame.
  - ln_done while ln_start = 0 (REL/IDLE): ignored.
  - frame_tick in the same cycle as frame_done: ignored, because the state is not yet IDLE.
  - Reset mid-operation: ln_start drops immediately and positions return to Y_INIT. The drawer is not otherwise notified.

Test Plan:
- Reset and idle: assert reset, release, no frame_tick -> ln_start=0, busy=0, l_y=r_y=104, for 100 cycles.
- Basic frame: use a drawer model that pulses ln_done 33 cycles after a start rise. Pulse frame_tick with no buttons -> command sequence is:
  - (x10, y104, c0), (x10, y104, c1), (x309, y104, c0), (x309, y104, c1);
  - ln_start low exactly 1 cycle between commands;
  - frame_done pulses once; busy falls the same cycle.
- Movement: l_down=1, r_up=1 at the tick -> left erase at y104, draw at y106; right erase at y104, draw at y102; l_y=106, r_y=102 after the frame.
- Clamping:
  - Hold l_up for 60 frames -> l_y reaches 0 and stays 0.
  - Hold r_down for 80 frames -> r_y stops at 208.
  - Both buttons pressed -> no change.
- Tick while busy: second frame_tick mid-DRAW -> ignored; exactly 4 commands issued, 1 frame_done.
- Async reset mid-ERASE: reset asserted between clock edges -> ln_start falls without waiting for a clock edge; l_y=104 after release; next frame_tick restarts at the left-paddle erase.
